// File: rtl/butterfly_result_writer_pkg.sv
// Shared FFT definitions: default widths and the width helpers used by the
// result-writer slice.
package butterfly_result_writer_pkg;

  localparam int FFT_OWL        = 16;
  localparam int FFT_ADDR_WL    = 10;
  localparam int FFT_FIFO_DEPTH = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Keeps derived widths legal for degenerate parameter values.
  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/butterfly_result_writer_fifo.sv
// Address FIFO holding destination address pairs between butterfly issue and
// result; head is presented combinationally.
module butterfly_addr_fifo
  import butterfly_result_writer_pkg::*;
#(
  parameter  int W     = 20,
  parameter  int DEPTH = 8,
  localparam int AW    = max1(clog2(DEPTH))
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push, w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/butterfly_result_writer.sv
// Pairs butterfly results with their queued destination addresses, writes them
// to the dual-port data RAM, and tracks stage progress and overflow risk.
module butterfly_result_writer
  import butterfly_result_writer_pkg::*;
#(
  parameter  int OWL        = FFT_OWL,
  parameter  int ADDR_WL    = FFT_ADDR_WL,
  parameter  int FIFO_DEPTH = FFT_FIFO_DEPTH,
  localparam int SW         = max1(clog2(ADDR_WL))
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic               issue_strb,
  input  logic [ADDR_WL-1:0] issue_addr1,
  input  logic [ADDR_WL-1:0] issue_addr2,
  input  logic               res_strb,
  input  logic [OWL-1:0]     res1_re,
  input  logic [OWL-1:0]     res1_im,
  input  logic [OWL-1:0]     res2_re,
  input  logic [OWL-1:0]     res2_im,
  output logic               wr_en,
  output logic [ADDR_WL-1:0] wr_addr1,
  output logic [ADDR_WL-1:0] wr_addr2,
  output logic [OWL-1:0]     wr1_re,
  output logic [OWL-1:0]     wr1_im,
  output logic [OWL-1:0]     wr2_re,
  output logic [OWL-1:0]     wr2_im,
  output logic [SW-1:0]      stage,
  output logic               stage_done,
  output logic               fft_done,
  output logic               scale_req,
  output logic               fifo_full,
  output logic               err_ovf,
  output logic               err_unf
);

  localparam int CW = max1(clog2(FIFO_DEPTH)) + 1;
  localparam logic [ADDR_WL-2:0] CNT_LAST   = '1;
  localparam logic [SW-1:0]      STAGE_LAST = SW'(ADDR_WL - 1);

  typedef struct packed {
    logic [ADDR_WL-1:0] a1;
    logic [ADDR_WL-1:0] a2;
  } addr_pair_t;

  typedef struct packed {
    logic [OWL-1:0] re1;
    logic [OWL-1:0] im1;
    logic [OWL-1:0] re2;
    logic [OWL-1:0] im2;
  } res_t;

  addr_pair_t       w_din, w_head, r_addr;
  res_t             r_res;
  logic             w_push, w_pop, w_full, w_empty, w_risk;
  logic [CW-1:0]    w_count;
  logic             r_wr_en, r_sd, r_fd, r_acc, r_scale, r_ovf, r_unf;
  logic [ADDR_WL-2:0] r_cnt;
  logic [SW-1:0]    r_stage;

  assign w_din  = '{a1: issue_addr1, a2: issue_addr2};
  // Results are never bypassed to a same-cycle issue: only a queued address pops.
  assign w_pop  = en & res_strb & ~w_empty;
  assign w_push = en & issue_strb & (~w_full | w_pop);

  butterfly_addr_fifo #(.W(2*ADDR_WL), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (clr),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // A word is at risk when its top two bits disagree (no headroom left).
  always_comb begin
    w_risk = (r_res.re1[OWL-1] ^ r_res.re1[OWL-2]) |
             (r_res.im1[OWL-1] ^ r_res.im1[OWL-2]) |
             (r_res.re2[OWL-1] ^ r_res.re2[OWL-2]) |
             (r_res.im2[OWL-1] ^ r_res.im2[OWL-2]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_stage <= '0;
      r_sd    <= 1'b0;
      r_fd    <= 1'b0;
      r_acc   <= 1'b0;
      r_scale <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (clr) begin
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_stage <= '0;
      r_sd    <= 1'b0;
      r_fd    <= 1'b0;
      r_acc   <= 1'b0;
      r_scale <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (en) begin
      r_wr_en <= w_pop;
      if (w_pop) begin
        r_addr <= w_head;
        r_res  <= '{re1: res1_re, im1: res1_im, re2: res2_re, im2: res2_im};
      end
      r_sd <= 1'b0;
      r_fd <= 1'b0;
      // Stage bookkeeping follows the write currently on the RAM port.
      if (r_wr_en) begin
        r_cnt <= r_cnt + (ADDR_WL-1)'(1);
        if (r_cnt == CNT_LAST) begin
          r_sd    <= 1'b1;
          r_scale <= r_acc | w_risk;
          r_acc   <= 1'b0;
          if (r_stage == STAGE_LAST) begin
            r_fd    <= 1'b1;
            r_stage <= '0;
          end else begin
            r_stage <= r_stage + SW'(1);
          end
        end else begin
          r_acc <= r_acc | w_risk;
        end
      end
      if (res_strb & w_empty)          r_unf <= 1'b1;
      if (issue_strb & w_full & ~w_pop) r_ovf <= 1'b1;
    end
  end

  // Held-off writes and pulses reappear once the enable returns.
  assign wr_en      = r_wr_en & en;
  assign stage_done = r_sd & en;
  assign fft_done   = r_fd & en;
  assign wr_addr1   = r_addr.a1;
  assign wr_addr2   = r_addr.a2;
  assign wr1_re     = r_res.re1;
  assign wr1_im     = r_res.im1;
  assign wr2_re     = r_res.re2;
  assign wr2_im     = r_res.im2;
  assign stage      = r_stage;
  assign scale_req  = r_scale;
  assign err_ovf    = r_ovf;
  assign err_unf    = r_unf;
  assign fifo_full  = (w_count == CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_butterfly_result_writer.sv
// Randomized and directed bench for butterfly_result_writer (ADDR_WL=3, depth 8)
// against a queue-based behavioural model checked every cycle.
module tb_butterfly_result_writer;

  localparam int OWL   = 16;
  localparam int AWL   = 3;
  localparam int DEPTH = 8;
  localparam int HALF  = 1 << (AWL - 1);
  localparam int NST   = AWL;

  logic clk, rst, en, clr, issue_strb, res_strb;
  logic [AWL-1:0] issue_addr1, issue_addr2;
  logic [OWL-1:0] res1_re, res1_im, res2_re, res2_im;
  logic wr_en, stage_done, fft_done, scale_req, fifo_full, err_ovf, err_unf;
  logic [AWL-1:0] wr_addr1, wr_addr2;
  logic [OWL-1:0] wr1_re, wr1_im, wr2_re, wr2_im;
  logic [1:0] stage;

  butterfly_result_writer #(.OWL(OWL), .ADDR_WL(AWL), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .issue_strb(issue_strb), .issue_addr1(issue_addr1), .issue_addr2(issue_addr2),
    .res_strb(res_strb), .res1_re(res1_re), .res1_im(res1_im),
    .res2_re(res2_re), .res2_im(res2_im),
    .wr_en(wr_en), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2),
    .wr1_re(wr1_re), .wr1_im(wr1_im), .wr2_re(wr2_re), .wr2_im(wr2_im),
    .stage(stage), .stage_done(stage_done), .fft_done(fft_done),
    .scale_req(scale_req), .fifo_full(fifo_full),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // ---------------- behavioural model ----------------
  logic [2*AWL-1:0] q[$];
  bit          m_wr_en, m_sd, m_fd, m_acc, m_scale, m_ovf, m_unf;
  logic [AWL-1:0] m_a1, m_a2;
  logic [OWL-1:0] m_d[4];
  int          m_writes, m_stage;

  function automatic bit risky(input logic [OWL-1:0] w);
    return w[OWL-1] != w[OWL-2];
  endfunction

  function automatic void model_reset();
    q.delete();
    m_wr_en = 0; m_sd = 0; m_fd = 0; m_acc = 0; m_scale = 0; m_ovf = 0; m_unf = 0;
    m_a1 = '0; m_a2 = '0;
    for (int i = 0; i < 4; i++) m_d[i] = '0;
    m_writes = 0; m_stage = 0;
  endfunction

  function automatic void model_step();
    bit pop, push;
    logic [2*AWL-1:0] head;
    if (clr) begin model_reset(); return; end
    if (!en) return;
    m_sd = 0; m_fd = 0;
    if (m_wr_en) begin
      m_writes++;
      m_acc = m_acc | risky(m_d[0]) | risky(m_d[1]) | risky(m_d[2]) | risky(m_d[3]);
      if (m_writes % HALF == 0) begin
        m_sd    = 1;
        m_scale = m_acc;
        m_acc   = 0;
        m_stage = (m_writes / HALF) % NST;
        m_fd    = (m_stage == 0);
      end
    end
    pop  = res_strb && (q.size() > 0);
    push = issue_strb && (q.size() < DEPTH || pop);
    if (res_strb && q.size() == 0) m_unf = 1;
    if (issue_strb && q.size() == DEPTH && !pop) m_ovf = 1;
    m_wr_en = pop;
    if (pop) begin
      head = q.pop_front();
      m_a1 = head[2*AWL-1:AWL];
      m_a2 = head[AWL-1:0];
      m_d[0] = res1_re; m_d[1] = res1_im; m_d[2] = res2_re; m_d[3] = res2_im;
    end
    if (push) q.push_back({issue_addr1, issue_addr2});
  endfunction

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Single compare process, away from the rising edge.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("wr_en",      32'(wr_en),      32'(m_wr_en && en));
      cmp("wr_addr1",   32'(wr_addr1),   32'(m_a1));
      cmp("wr_addr2",   32'(wr_addr2),   32'(m_a2));
      cmp("wr1_re",     32'(wr1_re),     32'(m_d[0]));
      cmp("wr1_im",     32'(wr1_im),     32'(m_d[1]));
      cmp("wr2_re",     32'(wr2_re),     32'(m_d[2]));
      cmp("wr2_im",     32'(wr2_im),     32'(m_d[3]));
      cmp("stage",      32'(stage),      32'(m_stage));
      cmp("stage_done", 32'(stage_done), 32'(m_sd && en));
      cmp("fft_done",   32'(fft_done),   32'(m_fd && en));
      cmp("scale_req",  32'(scale_req),  32'(m_scale));
      cmp("fifo_full",  32'(fifo_full),  32'(q.size() == DEPTH));
      cmp("err_ovf",    32'(err_ovf),    32'(m_ovf));
      cmp("err_unf",    32'(err_unf),    32'(m_unf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    if (!rst) model_reset(); else model_step();
    #1;
  endtask

  task automatic set_in(input bit iss, input int a1, input int a2, input bit rs,
                        input logic [OWL-1:0] d0, input logic [OWL-1:0] d1,
                        input logic [OWL-1:0] d2, input logic [OWL-1:0] d3);
    issue_strb = iss; issue_addr1 = AWL'(a1); issue_addr2 = AWL'(a2);
    res_strb = rs; res1_re = d0; res1_im = d1; res2_re = d2; res2_im = d3;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic do_clr();
    idle(); clr = 1'b1; cyc(); clr = 1'b0;
  endtask

  // Four issue/result pairs, one word of the write at index risky_idx at risk.
  task automatic run_stage(input int risky_idx);
    for (int k = 0; k < HALF + 3; k++) begin
      set_in(k < HALF, k, k + 4, (k >= 1) && (k <= HALF),
             16'h0010, 16'h0020, 16'h0030,
             ((k - 1) == risky_idx) ? 16'h4000 : 16'h0040);
      cyc();
    end
  endtask

  function automatic logic [OWL-1:0] rnd_word();
    if ($urandom_range(0, 3) == 0) return OWL'($urandom);
    return OWL'($urandom_range(0, 16'h3FFF));
  endfunction

  int log_sd[8];
  int nlog, fft_at, nfft, seen;

  initial begin
    rst = 1'b1; en = 1'b1; clr = 1'b0; idle();
    model_reset();
    #2 rst = 1'b0;
    #1 model_reset();
    chk_on = 1'b1;
    cyc(); cyc();
    cmp("rst_wr_en", 32'(wr_en), 0);
    cmp("rst_stage", 32'(stage), 0);
    cmp("rst_errs",  32'({err_ovf, err_unf, scale_req, fifo_full}), 0);
    rst = 1'b1;
    cyc();

    // Single butterfly: issue (3,7), result two cycles later, write one after.
    set_in(1, 3, 7, 0, 16'h0, 16'h0, 16'h0, 16'h0); cyc();
    idle(); cyc();
    set_in(0, 0, 0, 1, 16'h0100, 16'h0200, 16'h0300, 16'h0400); cyc();
    cmp("single_wr_en",  32'(wr_en), 1);
    cmp("single_addr1",  32'(wr_addr1), 3);
    cmp("single_addr2",  32'(wr_addr2), 7);
    cmp("single_d1",     32'({wr1_re, wr1_im}), 32'h0100_0200);
    cmp("single_d2",     32'({wr2_re, wr2_im}), 32'h0300_0400);
    idle(); cyc();
    cmp("single_one_shot", 32'(wr_en), 0);

    // Full FFT of 12 writes, pipelined issue/result.
    do_clr();
    nlog = 0; fft_at = -1; nfft = 0; seen = 0;
    for (int k = 0; k < 15; k++) begin
      set_in(k < 12, k % 8, (k + 1) % 8, (k >= 1) && (k <= 12),
             16'(k), 16'(k + 1), 16'(k + 2), 16'(k + 3));
      cyc();
      if (stage_done) begin
        if (nlog < 8) log_sd[nlog] = seen;
        if (fft_done) fft_at = nlog;
        nlog++;
      end
      if (fft_done) nfft++;
      if (wr_en) seen++;
    end
    cmp("fft_n_stage_done", 32'(nlog), 3);
    cmp("fft_sd_at_0", 32'(log_sd[0]), 4);
    cmp("fft_sd_at_1", 32'(log_sd[1]), 8);
    cmp("fft_sd_at_2", 32'(log_sd[2]), 12);
    cmp("fft_done_idx", 32'(fft_at), 2);
    cmp("fft_done_cnt", 32'(nfft), 1);
    cmp("fft_stage_wrap", 32'(stage), 0);

    // Overflow: nine issues into an eight-deep FIFO, then drain in order.
    do_clr();
    for (int k = 0; k < 9; k++) begin
      set_in(1, k, 7 - k, 0, 16'h0, 16'h0, 16'h0, 16'h0); cyc();
      if (k == 7) begin
        cmp("ovf_full_at_8", 32'(fifo_full), 1);
        cmp("ovf_not_yet",   32'(err_ovf), 0);
      end
    end
    cmp("ovf_flag", 32'(err_ovf), 1);
    for (int k = 0; k < 8; k++) begin
      set_in(0, 0, 0, 1, 16'(k), 16'h1, 16'h2, 16'h3); cyc();
      if (k == 0) cmp("ovf_first_addr", 32'({wr_addr1, wr_addr2}), 32'({3'd0, 3'd7}));
      if (k == 7) cmp("ovf_last_addr",  32'({wr_addr1, wr_addr2}), 32'({3'd7, 3'd0}));
    end
    idle(); cyc();
    cmp("ovf_drained", 32'(fifo_full), 0);

    // Underflow: empty result, then result with simultaneous issue.
    do_clr();
    set_in(0, 0, 0, 1, 16'h1111, 16'h0, 16'h0, 16'h0); cyc();
    cmp("unf_no_write", 32'(wr_en), 0);
    cmp("unf_flag",     32'(err_unf), 1);
    do_clr();
    set_in(1, 5, 6, 1, 16'h2222, 16'h0, 16'h0, 16'h0); cyc();
    cmp("unf_bypass_flag",  32'(err_unf), 1);
    cmp("unf_bypass_nowr",  32'(wr_en), 0);
    set_in(0, 0, 0, 1, 16'h3333, 16'h0, 16'h0, 16'h0); cyc();
    cmp("unf_queued_addr", 32'({wr_en, wr_addr1, wr_addr2}), 32'({1'b1, 3'd5, 3'd6}));
    idle(); cyc();

    // Scale request: at-risk word on the last write of a stage, then clean stage.
    do_clr();
    run_stage(HALF - 1);
    cmp("scale_set",   32'(scale_req), 1);
    run_stage(-1);
    cmp("scale_clear", 32'(scale_req), 0);

    // Randomized traffic with enable gaps and rare clears.
    do_clr();
    for (int n = 0; n < 1500; n++) begin
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 199) == 0);
      set_in($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1), rnd_word(), rnd_word(), rnd_word(), rnd_word());
      cyc();
    end
    en = 1'b1; clr = 1'b0; idle(); cyc();

    // Async reset with three addresses still pending and a write on the port.
    do_clr();
    for (int k = 0; k < 4; k++) begin
      set_in(1, k, k, 0, 16'h0, 16'h0, 16'h0, 16'h0); cyc();
    end
    set_in(0, 0, 0, 1, 16'h7777, 16'h7777, 16'h7777, 16'h7777); cyc();
    idle();
    rst = 1'b0;
    #1 model_reset();
    cmp("async_rst_wr",   32'({wr_en, wr_addr1, wr_addr2}), 0);
    cmp("async_rst_data", 32'({wr1_re, wr2_im}), 0);
    cmp("async_rst_flags", 32'({stage, stage_done, fft_done, scale_req, fifo_full, err_ovf, err_unf}), 0);
    cyc();
    rst = 1'b1;
    set_in(0, 0, 0, 1, 16'h1234, 16'h0, 16'h0, 16'h0); cyc();
    cmp("post_rst_unf",  32'(err_unf), 1);
    cmp("post_rst_nowr", 32'(wr_en), 0);
    idle(); cyc(); cyc();

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
